// File: rtl/branch_pc_unit_pkg.sv
// Shared types and constants for the branch / fetch-PC unit.
// FSM encoding, PC defaults and the sequential fetch step.
package branch_pc_unit_pkg;

    typedef enum logic {
        RUN = 1'b0,
        EXC = 1'b1
    } bpu_state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC_DEF = 32'h0000_0100;
    localparam logic [31:0] PC_STEP      = 32'd4;

endpackage

// File: rtl/branch_pc_unit_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
// Holds at all-ones once reached.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/branch_pc_unit.sv
// ID-stage branch resolution, fetch PC register and misaligned-target trap.
// Redirects fetch with a one-bubble penalty and keeps branch statistics.
module branch_pc_unit
    import branch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEF,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_if,
    input  logic             id_valid,
    input  logic             id_is_branch,
    input  logic             id_is_jal,
    input  logic             id_is_jalr,
    input  logic [31:0]      id_pc,
    input  logic [31:0]      id_imm,
    input  logic [31:0]      id_rs1_val,
    input  logic             cmp_result,
    input  logic             exc_ack,
    output logic [31:0]      pc_out,
    output logic             if_id_flush,
    output logic             redirect,
    output logic             misalign_exc,
    output logic [31:0]      misalign_addr,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
);

    bpu_state_e  state_q, state_d;
    logic [31:0] pc_d;
    logic        exc_d;
    logic [31:0] addr_d;
    logic [31:0] target;
    logic        take;
    logic        misal;
    logic        is_cond;
    logic        cnt_inc;
    logic        tkn_inc;

    // JALR wins over JAL/branch when the decoder misbehaves
    always_comb begin
        target = id_pc + id_imm;
        if (id_is_jalr) begin
            target = (id_rs1_val + id_imm) & ~32'h1;
        end
    end

    assign take = id_valid &
                  (id_is_jalr | id_is_jal | (id_is_branch & cmp_result));
    assign misal   = take & (target[1:0] != 2'b00);
    assign is_cond = id_valid & id_is_branch & ~id_is_jal & ~id_is_jalr;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_out;
        exc_d       = misalign_exc;
        addr_d      = misalign_addr;
        if_id_flush = 1'b0;
        redirect    = 1'b0;
        unique case (state_q)
            RUN: begin
                if (misal) begin
                    state_d     = EXC;
                    exc_d       = 1'b1;
                    addr_d      = target;
                    if_id_flush = 1'b1;
                end else if (take) begin
                    pc_d        = target;
                    redirect    = 1'b1;
                    if_id_flush = 1'b1;
                end else if (!stall_if) begin
                    pc_d = pc_out + PC_STEP;
                end
            end
            EXC: begin
                if_id_flush = 1'b1;
                if (exc_ack) begin
                    pc_d    = TRAP_VEC;
                    exc_d   = 1'b0;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        if (rst) begin
            if_id_flush = 1'b0;
            redirect    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            pc_out        <= RESET_PC;
            misalign_exc  <= 1'b0;
            misalign_addr <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_out        <= pc_d;
            misalign_exc  <= exc_d;
            misalign_addr <= addr_d;
        end
    end

    assign cnt_inc = (state_q == RUN) & is_cond;
    assign tkn_inc = cnt_inc & cmp_result;

    sat_counter #(.W(CNT_W)) u_branch_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (cnt_inc),
        .count (branch_count)
    );

    sat_counter #(.W(CNT_W)) u_taken_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (tkn_inc),
        .count (taken_count)
    );

    always_ff @(posedge clk) begin
        if (!rst && id_valid) begin
            assert ($onehot0({id_is_branch, id_is_jal, id_is_jalr}))
            else $error("multiple control-transfer flags in ID");
        end
    end

endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
- Consumes the ID-stage branch comparator's 1-bit result and owns the fetch PC register.
- Resolves conditional branches, JAL and JALR in ID, and computes the target.
- Redirects fetch and flushes the IF/ID register.
- Traps on misaligned targets; keeps branch statistics counters for perf debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VEC, 32'h0000_0100, PC loaded on exc_ack after a misaligned-target trap.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_if  in  1  hold PC (hazard unit); lower priority than redirect.
- id_valid  in  1  ID instruction is real and not stalled (hazard unit deasserts it on stall).
- id_is_branch  in  1  ID instruction is a conditional branch.
- id_is_jal  in  1  ID instruction is JAL.
- id_is_jalr  in  1  ID instruction is JALR.
- id_pc  in  32  PC of the ID instruction.
- id_imm  in  32  sign-extended immediate.
- id_rs1_val  in  32  forwarded rs1 value (JALR base).
- cmp_result  in  1  comparator output for the ID branch; 1 = condition true.
- exc_ack  in  1  trap handler acknowledge.
- pc_out  out  32  current fetch PC (registered).
- if_id_flush  out  1  kill the IF/ID contents on the next edge (combinational).
- redirect  out  1  taken, aligned control transfer this cycle (combinational).
- misalign_exc  out  1  misaligned-target trap pending (registered).
- misalign_addr  out  32  offending target (registered).
- branch_count  out  CNT_W  conditional branches resolved.
- taken_count  out  CNT_W  conditional branches taken.

Behaviour:
- Reset (sync, rst=1 at edge):
  - pc_out=RESET_PC; misalign_exc=0; misalign_addr=0; both counters=0; state=RUN.
  - if_id_flush and redirect evaluate to 0 while rst=1.
- Target computation, mod 2^32, carry discarded:
  - branch/JAL: id_pc+id_imm.
  - JALR: (id_rs1_val+id_imm) & ~32'h1.
- Multiple is_* flags high at once: priority JALR > JAL > branch (illegal per decoder; assert in sim).
- take = id_valid & (id_is_jalr | id_is_jal | (id_is_branch & cmp_result)).
- Misalignment: misal = take & (target[1:0]!=0). No compressed ISA, so bit1 set counts as misaligned.
- FSM has two states: RUN and EXC.
- RUN, priority order per cycle:
  1. take & misal: next state EXC; misalign_exc<=1; misalign_addr<=target; pc_out holds; if_id_flush=1; redirect=0.
  2. take & !misal: pc_out<=target; redirect=1; if_id_flush=1. Overrides stall_if.
  3. stall_if: pc_out holds; flush=0.
  4. Otherwise: pc_out<=pc_out+4, wrapping 32'hFFFF_FFFC -> 0.
- Branch penalty is exactly 1 bubble: the IF instruction is killed, and the target is fetched the cycle after resolution.
- EXC state:
  - id_valid, stall_if and cmp_result are ignored; pc_out holds; if_id_flush=1 every cycle; redirect=0.
  - On exc_ack=1 at an edge: pc_out<=TRAP_VEC; misalign_exc<=0; state<=RUN.
  - misalign_addr keeps its value until the next trap or reset.
  - exc_ack in RUN is ignored.
- Counters update in RUN only:
  - branch_count += 1 when id_valid & id_is_branch & !id_is_jal & !id_is_jalr.
  - taken_count += 1 when additionally cmp_result=1, including a misaligned taken branch.
  - Both saturate at all-ones.
- Reset mid-EXC or mid-redirect: rst wins and all state returns to reset values on that edge.

Decomposition:
- Shared package / Defines header holds:
  - FSM state encoding: RUN=1'b0, EXC=1'b1.
  - RESET_PC and TRAP_VEC defaults.
  - PC_STEP=4.
- One natural sub-module: sat_counter (parameter width; inc input; sync reset), instantiated twice.
- Target adder and FSM stay inline.

Test Plan:
- Reset then 3 free cycles: pc_out = 0, 4, 8, 12; if_id_flush=0 throughout.
- id_pc=0x40, id_imm=0x20, id_is_branch=1, cmp_result=1, id_valid=1 -> redirect=1 and flush=1 that cycle; next pc_out=0x60; branch_count=1; taken_count=1.
- Same branch with cmp_result=0 and stall_if=1 -> pc_out holds; flush=0; branch_count=1; taken_count=0.
- JALR with rs1=0x1003, imm=0 -> target 0x1002 (bit0 cleared) is misaligned:
  - next cycle misalign_exc=1, misalign_addr=0x1002, pc_out held.
  - flush stays 1 until exc_ack; then pc_out=0x100 and misalign_exc=0.
- pc_out=0xFFFF_FFFC with no stall -> pc_out=0x0. Also JAL with stall_if=1 and id_pc=0x8, imm=0x8 -> pc_out=0x10 (redirect beats stall).
- rst asserted in EXC -> next cycle pc_out=0, misalign_exc=0, counters 0; preload counters near CNT_W max (CNT_W=4) and confirm saturation at 4'hF.
